// File: rtl/mat_scalar_op_pkg.sv
// Shared types and helpers for the matrix-scalar arithmetic engine.
// Operation codes, float field positions and the sign-flip helper.
package mat_scalar_op_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_RSUB = 2'd3
   } op_t;

   localparam int FP_WIDTH    = 32;
   localparam int FP_SIGN_BIT = 31;

   function automatic logic [FP_WIDTH-1:0] fp_neg(input logic [FP_WIDTH-1:0] x);
      fp_neg = {~x[FP_SIGN_BIT], x[FP_SIGN_BIT-1:0]};
   endfunction

endpackage

// File: rtl/fp_scalar_lane.sv
// One float lane: multiply or add of an element with the scalar.
// Round-to-nearest-even, subnormals flushed to zero, two-cycle latency.
module fp_scalar_lane
   import mat_scalar_op_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  op_t         op,
   input  logic [31:0] a,
   input  logic [31:0] s,
   output logic        done,
   output logic [31:0] result
);

   function automatic logic [31:0] fp_pack(input logic sg, input logic signed [10:0] e,
                                           input logic [23:0] m, input logic g, input logic st);
      logic [24:0]        q;
      logic signed [10:0] ee;
      q  = {1'b0, m} + 25'(g & (st | m[0]));
      ee = e + 11'(q[24]);
      if (ee >= 11'sd255) return {sg, 8'hff, 23'd0};
      if (ee <= 11'sd0) return {sg, 31'd0};
      return {sg, ee[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0]        p;
      logic               sg;
      logic signed [10:0] e;
      sg = x[31] ^ y[31];
      if (x[30:23] == 8'hff || y[30:23] == 8'hff) begin
         if ((x[30:23] == 8'hff && x[22:0] != 0) || (y[30:23] == 8'hff && y[22:0] != 0) ||
             x[30:23] == 8'h00 || y[30:23] == 8'h00)
            return 32'h7fc00000;
         return {sg, 8'hff, 23'd0};
      end
      if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {sg, 31'd0};
      p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
      e = 11'(x[30:23]) + 11'(y[30:23]) - 11'sd127;
      if (p[47]) return fp_pack(sg, e + 11'sd1, p[47:24], p[23], |p[22:0]);
      return fp_pack(sg, e, p[46:23], p[22], |p[21:0]);
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]        u, v;
      logic [7:0]         d;
      logic [26:0]        mu, mv, sh, n;
      logic [27:0]        sum;
      logic signed [10:0] e;
      int                 lz;
      if (x[30:23] == 8'hff || y[30:23] == 8'hff) begin
         if ((x[30:23] == 8'hff && x[22:0] != 0) || (y[30:23] == 8'hff && y[22:0] != 0))
            return 32'h7fc00000;
         if (x[30:23] == 8'hff && y[30:23] == 8'hff && x[31] != y[31]) return 32'h7fc00000;
         return (x[30:23] == 8'hff) ? x : y;
      end
      if (x[30:0] >= y[30:0]) begin u = x; v = y; end
      else begin u = y; v = x; end
      if (u[30:23] == 8'h00) return {x[31] & y[31], 31'd0};
      if (v[30:23] == 8'h00) return u;
      d  = u[30:23] - v[30:23];
      mu = {1'b1, u[22:0], 3'b000};
      mv = {1'b1, v[22:0], 3'b000};
      sh = mv >> d;
      sh[0] = sh[0] | (|(mv & ~(27'h7ffffff << d)));
      sum = (u[31] ^ v[31]) ? {1'b0, mu} - {1'b0, sh} : {1'b0, mu} + {1'b0, sh};
      if (sum == 28'd0) return 32'd0;
      e = 11'(u[30:23]);
      if (sum[27]) begin
         n = {sum[27:2], sum[1] | sum[0]};
         e = e + 11'sd1;
      end else begin
         lz = 0;
         for (int i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
         n = sum[26:0] << lz;
         e = e - 11'(lz);
      end
      return fp_pack(u[31], e, n[26:3], n[2], |n[1:0]);
   endfunction

   op_t         op_q;
   logic [31:0] x_q, y_q;
   logic        act_q;

   // capture sign-adjusted operands on start, produce result one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_MUL;
         x_q    <= '0;
         y_q    <= '0;
         act_q  <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         act_q <= start;
         done  <= act_q;
         if (start) begin
            op_q <= op;
            x_q  <= (op == OP_RSUB) ? fp_neg(a) : a;
            y_q  <= (op == OP_SUB) ? fp_neg(s) : s;
         end
         if (act_q)
            result <= (op_q == OP_MUL) ? fp_mul(x_q, y_q) : fp_add(x_q, y_q);
      end
   end

endmodule

// File: rtl/mat_scalar_op.sv
// Element-wise matrix-scalar engine: mul/add/sub/rsub over float32.
// Elements run in batches across parallel lanes under a small FSM.
module mat_scalar_op
   import mat_scalar_op_pkg::*;
#(
   parameter int M       = 2,
   parameter int N       = 3,
   parameter int N_UNITS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  input_scalar,
   input  logic                         input_scalar_stb,
   output logic                         input_scalar_ack,
   input  logic [M-1:0][N-1:0][31:0]    input_mat,
   input  logic [1:0]                   input_op,
   input  logic                         input_mat_stb,
   output logic                         input_mat_ack,
   output logic [M-1:0][N-1:0][31:0]    output_mat,
   output logic                         output_mat_stb,
   input  logic                         output_mat_ack,
   output logic                         busy
);

   localparam int MN = M * N;
   localparam int NU = (N_UNITS > MN) ? MN : ((N_UNITS < 1) ? 1 : N_UNITS);
   localparam int NB = (MN + NU - 1) / NU;
   localparam int BW = $clog2(NB + 1);
   localparam int KW = (MN > 1) ? $clog2(MN) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LATCH = 2'd1;
   localparam logic [1:0] S_COMP  = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]             state;
   logic [31:0]            s_q;
   logic [MN-1:0][31:0]    a_q, r_q;
   op_t                    op_q;
   logic [BW-1:0]          b_q;
   logic                   run_q;
   logic [NU-1:0]          pend_q, pend_nx, start, done;
   logic [NU-1:0][31:0]    lane_a, lane_r;
   logic [NU-1:0][KW-1:0]  lane_k;
   logic                   take;

   assign take             = (state == S_IDLE) && input_scalar_stb && input_mat_stb;
   assign input_scalar_ack = take;
   assign input_mat_ack    = take;
   assign output_mat_stb   = (state == S_OUT);
   assign busy             = (state != S_IDLE);
   assign output_mat       = r_q;

   // map each lane onto its element of the current batch
   always_comb begin : p_sel
      int k;
      for (int u = 0; u < NU; u++) begin
         k         = int'(b_q) * NU + u;
         lane_a[u] = '0;
         lane_k[u] = '0;
         start[u]  = 1'b0;
         if (k < MN) begin
            lane_k[u] = KW'(k);
            lane_a[u] = a_q[KW'(k)];
            start[u]  = (state == S_COMP) && !run_q;
         end
      end
      pend_nx = pend_q & ~done;
   end

   for (genvar u = 0; u < NU; u++) begin : g_lane
      fp_scalar_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .start  (start[u]),
         .op     (op_q),
         .a      (lane_a[u]),
         .s      (s_q),
         .done   (done[u]),
         .result (lane_r[u])
      );
   end

   // batch controller and result collection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         s_q    <= '0;
         a_q    <= '0;
         r_q    <= '0;
         op_q   <= OP_MUL;
         b_q    <= '0;
         run_q  <= 1'b0;
         pend_q <= '0;
      end else begin
         for (int u = 0; u < NU; u++)
            if (done[u]) r_q[lane_k[u]] <= lane_r[u];
         unique case (state)
            S_IDLE: if (take) begin
               s_q   <= input_scalar;
               a_q   <= input_mat;
               op_q  <= op_t'(input_op);
               state <= S_LATCH;
            end
            S_LATCH: begin
               b_q   <= '0;
               run_q <= 1'b0;
               state <= S_COMP;
            end
            S_COMP: if (!run_q) begin
               run_q  <= 1'b1;
               pend_q <= start;
            end else begin
               pend_q <= pend_nx;
               if (pend_nx == '0) begin
                  run_q <= 1'b0;
                  b_q   <= b_q + 1'b1;
                  if (b_q == BW'(NB - 1)) state <= S_OUT;
               end
            end
            S_OUT: if (output_mat_ack) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_scalar_op.sv
// Self-checking bench for mat_scalar_op with 4-, 8- and 1-lane instances.
// Expected values come from a real-arithmetic reference model.
module tb_mat_scalar_op;
   import mat_scalar_op_pkg::*;

   logic         clk = 0;
   logic         rst;
   logic [31:0]  scal;
   logic [191:0] mat;
   logic [1:0]   op;
   logic [2:0]   sstb, mstb, oack;
   wire  [2:0]   sack, mack, ostb, bsy;
   wire  [191:0] omat [3];
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   mat_scalar_op #(.M(2), .N(3), .N_UNITS(4)) dut0 (
      .clk(clk), .rst(rst), .input_scalar(scal), .input_scalar_stb(sstb[0]),
      .input_scalar_ack(sack[0]), .input_mat(mat), .input_op(op), .input_mat_stb(mstb[0]),
      .input_mat_ack(mack[0]), .output_mat(omat[0]), .output_mat_stb(ostb[0]),
      .output_mat_ack(oack[0]), .busy(bsy[0]));
   mat_scalar_op #(.M(2), .N(3), .N_UNITS(8)) dut1 (
      .clk(clk), .rst(rst), .input_scalar(scal), .input_scalar_stb(sstb[1]),
      .input_scalar_ack(sack[1]), .input_mat(mat), .input_op(op), .input_mat_stb(mstb[1]),
      .input_mat_ack(mack[1]), .output_mat(omat[1]), .output_mat_stb(ostb[1]),
      .output_mat_ack(oack[1]), .busy(bsy[1]));
   mat_scalar_op #(.M(2), .N(3), .N_UNITS(1)) dut2 (
      .clk(clk), .rst(rst), .input_scalar(scal), .input_scalar_stb(sstb[2]),
      .input_scalar_ack(sack[2]), .input_mat(mat), .input_op(op), .input_mat_stb(mstb[2]),
      .input_mat_ack(mack[2]), .output_mat(omat[2]), .output_mat_stb(ostb[2]),
      .output_mat_ack(oack[2]), .busy(bsy[2]));

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 0) return $bitstoreal({f[31], 63'd0});
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] q;
      int          e;
      d = $realtobits(r);
      if (d[62:0] == 0) return {d[63], 31'd0};
      e = int'(d[62:52]) - 1023 + 127;
      q = {2'b01, d[51:29]} + 25'(d[28] & ((|d[27:0]) | d[29]));
      if (q[24]) e++;
      return {d[63], 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s);
      real x, y;
      x = f2r(a);
      y = f2r(s);
      case (o)
         2'd0:    return r2f(x * y);
         2'd1:    return r2f(x + y);
         2'd2:    return r2f(x - y);
         default: return r2f(y - x);
      endcase
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   task automatic randomize_ops();
      scal = rnd_f();
      for (int k = 0; k < 6; k++) mat[k*32 +: 32] = rnd_f();
      op = 2'($urandom_range(0, 3));
   endtask

   task automatic run_txn(input int sel, output logic [191:0] r, output int lat);
      int n;
      sstb[sel] = 1'b1;
      mstb[sel] = 1'b1;
      #1;
      n = 0;
      while (!sack[sel] && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      sstb[sel] = 1'b0;
      mstb[sel] = 1'b0;
      lat = 1;
      while (!ostb[sel] && lat < 500) begin
         @(negedge clk);
         lat++;
      end
      r = omat[sel];
      if (!ostb[sel] || n >= 100) lat = -1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bsy !== 3'b000 || ostb !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags busy=%b stb=%b want 000", bsy, ostb);
      end
      total++;
      if (omat[0] !== 192'd0) begin
         bad++;
         $display("FAIL reset_out got=%h want 0", omat[0]);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (sack !== 3'b000 || mack !== 3'b000 || bsy !== 3'b000) begin
         bad++;
         $display("FAIL reset_idle sack=%b mack=%b busy=%b want 0", sack, mack, bsy);
      end
   endtask

   task automatic test_mul_lanes();
      logic [191:0] r4, r8, r1;
      int           l4, l8, l1;
      logic [31:0]  ex [6];
      ex   = '{32'h40000000, 32'h40800000, 32'h40C00000,
               32'h41000000, 32'h41200000, 32'h41400000};
      scal = 32'h40000000;
      mat  = {32'h40C00000, 32'h40A00000, 32'h40800000,
              32'h40400000, 32'h40000000, 32'h3F800000};
      op   = 2'd0;
      run_txn(0, r4, l4);
      run_txn(1, r8, l8);
      for (int k = 0; k < 6; k++) begin
         total++;
         if (r4[k*32 +: 32] !== ex[k]) begin
            bad++;
            $display("FAIL mul4[%0d] got=%h want=%h", k, r4[k*32 +: 32], ex[k]);
         end
      end
      total++;
      if (r8 !== r4 || l8 < 0) begin
         bad++;
         $display("FAIL mul8 got=%h want=%h", r8, r4);
      end
      total++;
      if (l4 < 0 || l8 < 0 || l8 >= l4) begin
         bad++;
         $display("FAIL lane_latency lat8=%0d lat4=%0d want lat8<lat4", l8, l4);
      end
      scal = 32'h3F800000;
      run_txn(2, r1, l1);
      total++;
      if (r1 !== mat || l1 < 0) begin
         bad++;
         $display("FAIL mul1_ident got=%h want=%h", r1, mat);
      end
   endtask

   task automatic test_addsub();
      logic [191:0] r;
      int           l;
      logic [31:0]  ex [3][6];
      ex[0] = '{32'hBF800000, 32'h00000000, 32'h3F800000,
                32'h40000000, 32'h40400000, 32'h40800000};
      ex[1] = '{32'h40400000, 32'h40800000, 32'h40A00000,
                32'h40C00000, 32'h40E00000, 32'h41000000};
      ex[2] = '{32'hC0400000, 32'hC0800000, 32'hC0A00000,
                32'hC0C00000, 32'hC0E00000, 32'hC1000000};
      scal = 32'hC0000000;
      mat  = {32'h40C00000, 32'h40A00000, 32'h40800000,
              32'h40400000, 32'h40000000, 32'h3F800000};
      for (int t = 0; t < 3; t++) begin
         op = 2'(t + 1);
         run_txn(0, r, l);
         total++;
         if (l < 0) begin
            bad++;
            $display("FAIL addsub_timeout op=%0d got=%0d want>0", t + 1, l);
         end
         for (int k = 0; k < 6; k++) begin
            total++;
            if (r[k*32 +: 32] !== ex[t][k]) begin
               bad++;
               $display("FAIL addsub op=%0d [%0d] got=%h want=%h", t + 1, k, r[k*32 +: 32], ex[t][k]);
            end
         end
         if (t == 0) begin
            total++;
            if (r[63:32] !== 32'h00000000) begin
               bad++;
               $display("FAIL add_pos_zero got=%h want=00000000", r[63:32]);
            end
         end
      end
   endtask

   task automatic test_one_sided();
      logic ok;
      randomize_ops();
      mstb[0] = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (sack[0] || mack[0] || bsy[0]) ok = 1'b0;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL one_sided got=ack/busy seen want=none");
      end
      @(negedge clk);
      sstb[0] = 1'b1;
      #1;
      total++;
      if (sack[0] !== 1'b1 || mack[0] !== 1'b1) begin
         bad++;
         $display("FAIL both_ack sack=%b mack=%b want 11", sack[0], mack[0]);
      end
      @(negedge clk);
      #1;
      total++;
      if (sack[0] !== 1'b0 || mack[0] !== 1'b0) begin
         bad++;
         $display("FAIL ack_pulse sack=%b mack=%b want 00", sack[0], mack[0]);
      end
      sstb[0] = 1'b0;
      mstb[0] = 1'b0;
      repeat (60) @(negedge clk);
   endtask

   task automatic test_hold();
      logic [191:0] held, exv;
      logic         ok;
      int           n;
      randomize_ops();
      for (int k = 0; k < 6; k++) exv[k*32 +: 32] = model(op, mat[k*32 +: 32], scal);
      oack[0] = 1'b0;
      sstb[0] = 1'b1;
      mstb[0] = 1'b1;
      #1;
      n = 0;
      while (!sack[0] && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      sstb[0] = 1'b0;
      mstb[0] = 1'b0;
      n = 0;
      while (!ostb[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      held = omat[0];
      total++;
      if (ostb[0] !== 1'b1 || held !== exv) begin
         bad++;
         $display("FAIL hold_result got=%h want=%h", held, exv);
      end
      sstb[0] = 1'b1;
      mstb[0] = 1'b1;
      ok = 1'b1;
      repeat (50) begin
         @(negedge clk);
         #1;
         if (!ostb[0] || omat[0] !== held || sack[0] || mack[0]) ok = 1'b0;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL hold_stable got=change/ack want=stable");
      end
      oack[0] = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (ostb[0] !== 1'b0 || sack[0] !== 1'b1) begin
         bad++;
         $display("FAIL hold_release stb=%b ack=%b want 0/1", ostb[0], sack[0]);
      end
      @(negedge clk);
      sstb[0] = 1'b0;
      mstb[0] = 1'b0;
      n = 0;
      while (!ostb[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (ostb[0] !== 1'b1 || omat[0] !== exv) begin
         bad++;
         $display("FAIL hold_next got=%h want=%h", omat[0], exv);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [191:0] r, exv;
      logic         ok;
      int           n, l;
      randomize_ops();
      sstb[0] = 1'b1;
      mstb[0] = 1'b1;
      #1;
      n = 0;
      while (!sack[0] && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      sstb[0] = 1'b0;
      mstb[0] = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bsy[0] !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy got=%b want=1", bsy[0]);
      end
      rst = 1'b1;
      #1;
      total++;
      if (bsy[0] !== 1'b0 || ostb[0] !== 1'b0 || omat[0] !== 192'd0) begin
         bad++;
         $display("FAIL mid_reset busy=%b stb=%b out=%h want 0", bsy[0], ostb[0], omat[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (ostb[0] || bsy[0]) ok = 1'b0;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL mid_no_pulse got=stb/busy want=none");
      end
      randomize_ops();
      for (int k = 0; k < 6; k++) exv[k*32 +: 32] = model(op, mat[k*32 +: 32], scal);
      run_txn(0, r, l);
      total++;
      if (r !== exv || l < 0) begin
         bad++;
         $display("FAIL mid_after got=%h want=%h", r, exv);
      end
   endtask

   task automatic test_random();
      logic [191:0] r;
      logic [31:0]  e;
      int           l, sel;
      for (int t = 0; t < 24; t++) begin
         randomize_ops();
         sel = $urandom_range(0, 2);
         run_txn(sel, r, l);
         total++;
         if (l < 0) begin
            bad++;
            $display("FAIL rand_timeout dut=%0d got=%0d want>0", sel, l);
         end
         for (int k = 0; k < 6; k++) begin
            e = model(op, mat[k*32 +: 32], scal);
            total++;
            if (r[k*32 +: 32] !== e) begin
               bad++;
               $display("FAIL rand dut=%0d op=%0d [%0d] got=%h want=%h", sel, op, k, r[k*32 +: 32], e);
            end
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      sstb = '0;
      mstb = '0;
      oack = '1;
      scal = '0;
      mat  = '0;
      op   = '0;
      @(negedge clk);
      test_reset();
      test_mul_lanes();
      test_addsub();
      test_one_sided();
      test_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mat_scalar_op.md
Name: mat_scalar_op

Overview:
Element-wise matrix–scalar arithmetic engine for IEEE-754 single-precision M×N matrices. It is the generalised successor of the multiply-only matrix-scalar block, and supports four operations selected per transaction: multiply, add, subtract, and reverse-subtract. Elements are processed in batches across N_UNITS parallel float lanes. It sits in the linalg layer between the layer controller and downstream matrix consumers, and uses the standard stb/ack handshakes.

Parameters:
M, 2, matrix rows
N, 3, matrix columns
N_UNITS, 4, parallel lanes; valid 1..M*N (values above M*N are clipped to M*N)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
input_scalar  in  32  float32 scalar s
input_scalar_stb  in  1  scalar valid
input_scalar_ack  out  1  one-cycle pulse; scalar consumed
input_mat  in  [M-1:0][N-1:0][31:0]  float32 matrix A
input_op  in  2  op_t, sampled together with input_mat
input_mat_stb  in  1  matrix and op valid
input_mat_ack  out  1  one-cycle pulse; matrix and op consumed
output_mat  out  [M-1:0][N-1:0][31:0]  result R
output_mat_stb  out  1  result valid
output_mat_ack  in  1  result consumed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-high. On reset: FSM goes to IDLE; acks=0, output_mat_stb=0, output_mat=0, busy=0; all lanes are reset and in-flight results are discarded. Reset mid-compute or mid-output aborts with no output pulse.
- Operations on R[i][j], given A[i][j] and s:
  - OP_MUL: A*s.
  - OP_ADD: A+s.
  - OP_SUB: A-s, done by flipping the sign bit of s into the adder.
  - OP_RSUB: s-A, done by flipping the sign bit of A[i][j].
- Rounding and special values (NaN, Inf, zero sign) follow the team float cores; no extra handling.
- FSM states: IDLE -> LATCH -> COMPUTE -> OUTPUT -> IDLE.
- IDLE: wait until input_scalar_stb && input_mat_stb are both high in the same cycle. While only one is high, do not ack and do not latch. When both are high, latch s, A and op; pulse both acks high for exactly that one cycle; go to LATCH.
- LATCH: batch index b=0; go to COMPUTE.
- COMPUTE: flat index k=i*N+j. Batch b covers k = b*N_UNITS .. min((b+1)*N_UNITS, M*N)-1. Start all active lanes of the batch in the same cycle. Unused lanes in the final partial batch stay idle. Each lane's result is written into the output register as that lane finishes. When all active lanes are done: b++. When b reaches ceil(M*N/N_UNITS), go to OUTPUT.
- OUTPUT: output_mat_stb=1 and output_mat stays stable until the cycle output_mat_ack=1; in that cycle drop stb and go to IDLE.
- If output_mat_ack is held high permanently, stb is high for exactly one cycle.
- output_mat keeps its value after the handshake until overwritten in the next COMPUTE.
- No overlap between transactions: new operands are acked no earlier than the cycle after the output handshake.
- The lane count affects latency only. Results are bit-identical for any N_UNITS.

Decomposition:
- Package mat_scalar_op_pkg:
  - op_t enum (OP_MUL=2'd0, OP_ADD=2'd1, OP_SUB=2'd2, OP_RSUB=2'd3)
  - FP_WIDTH=32, FP_SIGN_BIT=31
  - function fp_neg (sign flip)
- Sub-module fp_scalar_lane: one lane. It wraps the team float multiplier and float adder with stb/ack, muxes by op, applies the sign flips, and exposes start/done/result. The top level instantiates N_UNITS lanes plus the batch controller FSM.

Test Plan:
- Scenario 1: M=2, N=3, s=32'h40000000 (2.0), A=[1,2,3;4,5,6], OP_MUL, ack tied 1 -> R=[2,4,6;8,10,12] (32'h40000000..32'h41400000). Check on N_UNITS=4 (two batches) and N_UNITS=8 (clipped to 6, one batch); both results must be identical, and the 8-lane latency must be strictly lower.
- Scenario 2: same A, s=32'hC0000000 (-2.0), cycling OP_ADD / OP_SUB / OP_RSUB ->
  - OP_ADD: R=[-1,0,1;2,3,4].
  - OP_SUB: R=[3,4,5;6,7,8].
  - OP_RSUB: R=[-3,-4,-5;-6,-7,-8]; also check the zero result of OP_ADD is +0 (32'h00000000).
- Scenario 3: input_mat_stb high, input_scalar_stb low for 20 cycles -> no acks, busy=0; then raise scalar_stb -> both acks pulse in the same single cycle.
- Scenario 4: output_mat_ack held low for 50 cycles -> output_mat_stb stays high, output_mat stays constant, no new input ack; raise ack -> stb drops the next cycle and the next transaction starts.
- Scenario 5: assert rst during COMPUTE -> busy=0, all outputs 0, no output_mat_stb pulse; the next transaction completes correctly.
- Scenario 6: N_UNITS=1 with OP_MUL, s=32'h3F800000 (1.0) -> R==A bit-exact after 6 sequential single-lane batches.
